// File: rtl/j1_loader.sv
// J1 program loader: receives a framed byte stream (sync, 16-bit word count,
// little-endian words, XOR checksum), writes each word into the J1 program
// store and holds the core in reset until a complete, valid image has arrived.
module j1_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_WORDS = 8192,
    parameter bit          BOOT_RUN  = 1'b0
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_n_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [15:0] pgm_addr_o,
    output logic [15:0] pgm_data_o,
    output logic        pgm_we_o,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StCntHi  = 3'd1;
    localparam logic [2:0] StCntLo  = 3'd2;
    localparam logic [2:0] StDataLo = 3'd3;
    localparam logic [2:0] StDataHi = 3'd4;
    localparam logic [2:0] StCsum   = 3'd5;
    localparam logic [2:0] StWrap   = 3'd6;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [14:0] idx_q, idx_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  csum_q, csum_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        we_q, we_d;
    logic        rdy_q, rdy_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        xfer;
    logic [15:0] cnt_full;
    logic        cnt_bad;
    logic        last_word;

    assign xfer      = rx_valid_i & rdy_q;
    // cnt_q holds the high count byte (in its low half) while in StCntLo
    assign cnt_full  = {cnt_q[7:0], rx_data_i};
    assign cnt_bad   = (cnt_full == 16'd0) || ({16'd0, cnt_full} > MAX_WORDS);
    assign last_word = ({1'b0, idx_q} == (cnt_q - 16'd1));

    // Next-state and datapath decode for the frame parser
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        lo_d      = lo_q;
        csum_d    = csum_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cpu_rst_d = cpu_rst_q;
        err_d     = err_q;
        we_d      = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                if (xfer && (rx_data_i == SYNC_BYTE)) begin
                    state_d   = StCntHi;
                    cpu_rst_d = 1'b1;
                    err_d     = 1'b0;
                    csum_d    = 8'h00;
                    idx_d     = '0;
                end
            end
            StCntHi: begin
                if (xfer) begin
                    cnt_d   = {8'h00, rx_data_i};
                    csum_d  = csum_q ^ rx_data_i;
                    state_d = StCntLo;
                end
            end
            StCntLo: begin
                if (xfer) begin
                    cnt_d  = cnt_full;
                    csum_d = csum_q ^ rx_data_i;
                    if (cnt_bad) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        state_d = StDataLo;
                    end
                end
            end
            StDataLo: begin
                if (xfer) begin
                    lo_d    = rx_data_i;
                    csum_d  = csum_q ^ rx_data_i;
                    state_d = StDataHi;
                end
            end
            StDataHi: begin
                if (xfer) begin
                    csum_d  = csum_q ^ rx_data_i;
                    we_d    = 1'b1;
                    data_d  = {rx_data_i, lo_q};
                    addr_d  = {idx_q, 1'b0};
                    idx_d   = idx_q + 15'd1;
                    state_d = last_word ? StCsum : StDataLo;
                end
            end
            StCsum: begin
                if (xfer) begin
                    if (rx_data_i == csum_q) begin
                        state_d   = StWrap;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWrap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Ready is registered so it can be low for the wrap cycle and the write cycle
    always_comb begin
        rdy_d = (state_d != StWrap) && !we_d;
    end

    // State registers; async reset aborts any load in progress
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            lo_q      <= '0;
            csum_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            rdy_q     <= 1'b0;
            cpu_rst_q <= ~BOOT_RUN;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            lo_q      <= lo_d;
            csum_q    <= csum_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            rdy_q     <= rdy_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign rx_ready_o = rdy_q;
    assign pgm_addr_o = addr_q;
    assign pgm_data_o = data_q;
    assign pgm_we_o   = we_q;
    assign cpu_rst_o  = cpu_rst_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_j1_loader.sv
// Bench for j1_loader: frames are built from a word list together with their
// XOR checksum, and observed program writes are compared against the word
// list placed at consecutive even byte addresses.
module tb_j1_loader;

    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] pgm_addr;
    logic [15:0] pgm_data;
    logic        pgm_we;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int total = 0;
    int bad = 0;

    logic [7:0]  fb[$];
    logic [15:0] exp_w[$];
    logic [15:0] wa[$];
    logic [15:0] wd[$];
    int          done_cnt = 0;
    int          rdy_viol = 0;

    always #5 clk = ~clk;

    j1_loader #(
        .SYNC_BYTE(SYNC),
        .MAX_WORDS(8192),
        .BOOT_RUN (1'b0)
    ) dut (
        .sys_clk_i  (clk),
        .sys_rst_n_i(rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .pgm_addr_o (pgm_addr),
        .pgm_data_o (pgm_data),
        .pgm_we_o   (pgm_we),
        .cpu_rst_o  (cpu_rst),
        .done_o     (done),
        .err_o      (err)
    );

    // Observe writes, done pulses and ready during no-accept cycles
    always @(negedge clk) begin
        if (pgm_we) begin
            wa.push_back(pgm_addr);
            wd.push_back(pgm_data);
        end
        if (done) done_cnt <= done_cnt + 1;
        if ((pgm_we || done) && rx_ready) rdy_viol <= rdy_viol + 1;
    end

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        done_cnt = 0;
        rdy_viol = 0;
    endtask

    // mode 0: correct checksum, 1: forced value, 2: corrupted checksum
    task automatic make_frame(input logic [15:0] n, input int mode, input logic [7:0] cval);
        logic [7:0] x;
        fb.delete();
        fb.push_back(SYNC);
        fb.push_back(n[15:8]);
        fb.push_back(n[7:0]);
        foreach (exp_w[i]) begin
            fb.push_back(exp_w[i][7:0]);
            fb.push_back(exp_w[i][15:8]);
        end
        x = 8'h00;
        for (int i = 1; i < fb.size(); i++) x = x ^ fb[i];
        if (mode == 0) fb.push_back(x);
        else if (mode == 1) fb.push_back(cval);
        else fb.push_back(x ^ 8'($urandom_range(1, 255)));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int guard;
        @(negedge clk);
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (!rx_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: rx_ready=%0b after %0d cycles, required 1", rx_ready, guard);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_frame(input bit gaps);
        foreach (fb[i]) send_byte(fb[i], gaps);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Index of first write disagreeing with exp_w at address 2*i, or -1
    function automatic int first_diff();
        for (int i = 0; i < exp_w.size(); i++) begin
            if (i >= wa.size()) return i;
            if (wa[i] !== 16'(2 * i) || wd[i] !== exp_w[i]) return i;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({rx_ready, pgm_we, done, err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: rdy/we/done/err=%b, required 0000",
                     {rx_ready, pgm_we, done, err});
        end
        total++;
        if (pgm_addr !== 16'h0 || pgm_data !== 16'h0) begin
            bad++;
            $display("FAIL reset_bus: addr=%h data=%h, required 0000 0000", pgm_addr, pgm_data);
        end
        total++;
        if (cpu_rst !== 1'b1) begin
            bad++;
            $display("FAIL reset_cpu_rst: got %b, required 1", cpu_rst);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (rx_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_clk: got %b, required 0", rx_ready);
        end
        @(posedge clk);
        #1;
        total++;
        if (rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_clk: got %b, required 1", rx_ready);
        end
    endtask

    task automatic check_load(input string tag, input int exp_done, input logic exp_err,
                              input logic exp_cpu);
        int d;
        d = first_diff();
        total++;
        if (wa.size() != exp_w.size() || d != -1) begin
            bad++;
            $display("FAIL %s_writes: count=%0d first_bad=%0d, required count=%0d all match",
                     tag, wa.size(), d, exp_w.size());
        end
        total++;
        if (done_cnt != exp_done) begin
            bad++;
            $display("FAIL %s_done: pulses=%0d, required %0d", tag, done_cnt, exp_done);
        end
        total++;
        if (err !== exp_err || cpu_rst !== exp_cpu) begin
            bad++;
            $display("FAIL %s_status: err=%b cpu_rst=%b, required err=%b cpu_rst=%b",
                     tag, err, cpu_rst, exp_err, exp_cpu);
        end
        total++;
        if (rdy_viol != 0) begin
            bad++;
            $display("FAIL %s_backpressure: ready-high violations=%0d, required 0", tag, rdy_viol);
        end
    endtask

    task automatic test_spec_frame();
        exp_w = '{16'h1234, 16'h5678};
        make_frame(16'd2, 0, 8'h00);
        clear_mon();
        send_frame(1'b0);
        check_load("spec", 1, 1'b0, 1'b0);
        total++;
        if (pgm_addr !== 16'h0002 || pgm_data !== 16'h5678) begin
            bad++;
            $display("FAIL hold_bus: addr=%h data=%h, required 0002 5678", pgm_addr, pgm_data);
        end
    endtask

    task automatic test_bad_csum();
        exp_w = '{16'h1234, 16'h5678};
        make_frame(16'd2, 1, 8'h00);
        clear_mon();
        send_byte(fb[0], 1'b0);
        #1;
        total++;
        if (cpu_rst !== 1'b1) begin
            bad++;
            $display("FAIL reassert_cpu_rst: got %b, required 1", cpu_rst);
        end
        fb.delete(0);
        send_frame(1'b0);
        check_load("badcsum", 0, 1'b1, 1'b1);
    endtask

    task automatic test_bad_count();
        exp_w.delete();
        clear_mon();
        fb = '{SYNC, 8'h00, 8'h00};
        send_frame(1'b1);
        check_load("cnt_zero", 0, 1'b1, 1'b1);
        fb = '{SYNC};
        send_frame(1'b0);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_clear_on_sync: got %b, required 0", err);
        end
        fb = '{8'h20, 8'h01};
        send_frame(1'b0);
        check_load("cnt_big", 0, 1'b1, 1'b1);
        // parser must be back in idle: a fresh single-word frame loads cleanly
        exp_w = '{16'hBEEF};
        make_frame(16'd1, 0, 8'h00);
        clear_mon();
        send_frame(1'b1);
        check_load("after_big", 1, 1'b0, 1'b0);
    endtask

    task automatic test_junk_and_stall();
        exp_w = '{16'h1234, 16'h5678};
        make_frame(16'd2, 0, 8'h00);
        clear_mon();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_frame(1'b1);
        check_load("junk_stall", 1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n;
            int junk;
            bit corrupt;
            logic [7:0] b;
            n       = $urandom_range(1, 12);
            junk    = $urandom_range(0, 3);
            corrupt = ($urandom_range(0, 3) == 0);
            exp_w.delete();
            for (int i = 0; i < n; i++) exp_w.push_back(16'($urandom));
            make_frame(16'(n), corrupt ? 2 : 0, 8'h00);
            clear_mon();
            for (int j = 0; j < junk; j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC) b = 8'h5A;
                send_byte(b, 1'b1);
            end
            send_frame(1'b1);
            check_load("random", corrupt ? 0 : 1, corrupt, 1'b1 & corrupt);
        end
    endtask

    task automatic test_reset_midframe();
        exp_w = '{16'h1111, 16'h2222, 16'h3333};
        make_frame(16'd3, 0, 8'h00);
        clear_mon();
        for (int i = 0; i < 5; i++) send_byte(fb[i], 1'b0);
        @(negedge clk);
        rx_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (rx_ready !== 1'b0 || pgm_we !== 1'b0 || cpu_rst !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: rdy=%b we=%b cpu_rst=%b, required 0 0 1",
                     rx_ready, pgm_we, cpu_rst);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 5; i < fb.size(); i++) send_byte(fb[i], 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (wa.size() != 1 || done_cnt != 0) begin
            bad++;
            $display("FAIL abort_writes: writes=%0d done=%0d, required 1 0", wa.size(), done_cnt);
        end else if (wa[0] !== 16'h0000 || wd[0] !== 16'h1111) begin
            total++;
            bad++;
            $display("FAIL abort_first: addr=%h data=%h, required 0000 1111", wa[0], wd[0]);
        end
        exp_w.delete();
        for (int i = 0; i < 4; i++) exp_w.push_back(16'($urandom));
        make_frame(16'd4, 0, 8'h00);
        clear_mon();
        send_frame(1'b1);
        check_load("after_reset", 1, 1'b0, 1'b0);
    endtask

    task automatic test_max_frame();
        logic [15:0] last;
        exp_w.delete();
        for (int i = 0; i < 8192; i++) exp_w.push_back(16'($urandom));
        make_frame(16'd8192, 0, 8'h00);
        clear_mon();
        send_frame(1'b0);
        check_load("max", 1, 1'b0, 1'b0);
        last = (wa.size() > 0) ? wa[wa.size() - 1] : 16'hFFFF;
        total++;
        if (last !== 16'h3FFE) begin
            bad++;
            $display("FAIL max_last_addr: got %h, required 3ffe", last);
        end
    endtask

    initial begin
        test_reset();
        test_spec_frame();
        test_bad_csum();
        test_bad_count();
        test_junk_and_stall();
        test_random();
        test_reset_midframe();
        test_max_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
